// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: opcode/memory handshake in, datapath control strobes out
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal_op;
  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op
  );
  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore main-control FSM for the multi-cycle MIPS datapath
module mips_multicycle_ctrl #(
  parameter bit JUMP_EN = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_multicycle_ctrl_if.master bus,
  output logic [CNT_W-1:0]     retired_cnt,
  output logic [3:0]           state_dbg
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9
  } state_t;
  state_t state, nxt;
  logic is_lw, is_sw, is_r, is_beq, is_j, done;
  assign is_lw  = bus.op == 6'b100011;
  assign is_sw  = bus.op == 6'b101011;
  assign is_r   = bus.op == 6'b000000;
  assign is_beq = bus.op == 6'b000100;
  assign is_j   = JUMP_EN && bus.op == 6'b000010;
  // next-state sequencing; unknown encodings fall back to FETCH
  always_comb
    case (state)
      FETCH:   nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE:  nxt = (is_lw || is_sw) ? MEMADDR : is_r ? EXEC : is_beq ? BRANCH : is_j ? JUMP : FETCH;
      MEMADDR: nxt = is_lw ? MEMRD : MEMWR;
      MEMRD:   nxt = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:   nxt = bus.mem_ready ? FETCH : MEMWR;
      EXEC:    nxt = RWB;
      default: nxt = FETCH;
    endcase
  // outputs follow the state, all held low while reset is asserted
  assign done              = rst_n && (state == MEMWB || state == RWB || state == BRANCH || state == JUMP ||
                                       (state == MEMWR && bus.mem_ready));
  assign bus.instr_done    = done;
  assign bus.illegal_op    = rst_n && state == DECODE && !(is_lw || is_sw || is_r || is_beq || is_j);
  assign bus.mem_read      = rst_n && (state == FETCH || state == MEMRD);
  assign bus.ir_write      = rst_n && state == FETCH && bus.mem_ready;
  assign bus.pc_write      = rst_n && ((state == FETCH && bus.mem_ready) || state == JUMP);
  assign bus.pc_write_cond = rst_n && state == BRANCH;
  assign bus.pc_source     = !rst_n ? 2'b00 : state == BRANCH ? 2'b01 : state == JUMP ? 2'b10 : 2'b00;
  assign bus.iord          = rst_n && (state == MEMRD || state == MEMWR);
  assign bus.mem_write     = rst_n && state == MEMWR;
  assign bus.mem_to_reg    = rst_n && state == MEMWB;
  assign bus.reg_write     = rst_n && (state == MEMWB || state == RWB);
  assign bus.reg_dst       = rst_n && state == RWB;
  assign bus.alu_src_a     = rst_n && (state == MEMADDR || state == EXEC || state == BRANCH);
  assign bus.alu_src_b     = !rst_n ? 2'b00 : state == FETCH ? 2'b01 : state == DECODE ? 2'b11 :
                             state == MEMADDR ? 2'b10 : 2'b00;
  assign bus.alu_op        = !rst_n ? 2'b00 : state == EXEC ? 2'b10 : state == BRANCH ? 2'b01 : 2'b00;
  assign state_dbg         = state;
  // state register and retired-instruction counter (wraps silently)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= FETCH;
      retired_cnt <= '0;
    end else begin
      state       <= nxt;
      retired_cnt <= retired_cnt + CNT_W'(done);
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: instruction-level model checked against two controller instances every cycle
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [31:0] cnt;
  logic [3:0] cnt4, sd, sd4;
  logic [17:0] v, v4, ev;
  int n_chk = 0, n_fail = 0, n_irw = 0;
  int m_k = 0, es;
  logic [31:0] m_cnt = '0;
  logic m_fin = 1'b0;
  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl_if bus4();
  assign bus4.op = bus.op;
  assign bus4.mem_ready = bus.mem_ready;
  mips_multicycle_ctrl #(.JUMP_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .retired_cnt(cnt), .state_dbg(sd));
  mips_multicycle_ctrl #(.JUMP_EN(1'b1), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .retired_cnt(cnt4), .state_dbg(sd4));
  always #5 clk = ~clk;
  assign v = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord, bus.mem_read, bus.mem_write,
              bus.ir_write, bus.mem_to_reg, bus.reg_write, bus.reg_dst, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op, bus.instr_done, bus.illegal_op};
  assign v4 = {bus4.pc_write, bus4.pc_write_cond, bus4.pc_source, bus4.iord, bus4.mem_read, bus4.mem_write,
               bus4.ir_write, bus4.mem_to_reg, bus4.reg_write, bus4.reg_dst, bus4.alu_src_a, bus4.alu_src_b,
               bus4.alu_op, bus4.instr_done, bus4.illegal_op};
  function automatic int plen(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011, 6'b000000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction
  function automatic int exp_state(input logic [5:0] o, input int k);
    if (k < 2) return k;
    case (o)
      6'b100011: return k;
      6'b101011: return k == 2 ? 2 : 5;
      6'b000000: return k + 4;
      6'b000100: return 8;
      6'b000010: return 9;
      default: return 0;
    endcase
  endfunction
  function automatic logic [17:0] exp_ctl(input int s, input logic mr, input logic [5:0] o);
    logic pcw, pwc, iord, rd, wr, irw, m2r, rw, rdst, sa, done, ill;
    logic [1:0] ps, sb, ao;
    {pcw, pwc, iord, rd, wr, irw, m2r, rw, rdst, sa, done, ill} = '0;
    ps = '0; sb = '0; ao = '0;
    case (s)
      0: begin rd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      1: begin sb = 2'b11; ill = plen(o) == 2; end
      2: begin sa = 1; sb = 2'b10; end
      3: begin rd = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; done = 1; end
      5: begin wr = 1; iord = 1; done = mr; end
      6: begin sa = 1; ao = 2'b10; end
      7: begin rw = 1; rdst = 1; done = 1; end
      8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; done = 1; end
      9: begin pcw = 1; ps = 2'b10; done = 1; end
      default: ;
    endcase
    return {pcw, pwc, ps, iord, rd, wr, irw, m2r, rw, rdst, sa, sb, ao, done, ill};
  endfunction
  function automatic bit is_mem(input int s);
    return s == 0 || s == 3 || s == 5;
  endfunction
  assign es = rst_n ? exp_state(bus.op, m_k) : 0;
  assign ev = rst_n ? exp_ctl(es, bus.mem_ready, bus.op) : '0;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, x, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_k <= 0;
      m_cnt <= '0;
      m_fin <= 1'b0;
    end else begin
      m_fin <= 1'b0;
      if (!(is_mem(exp_state(bus.op, m_k)) && !bus.mem_ready)) begin
        if (m_k == plen(bus.op) - 1) begin
          m_k <= 0;
          m_fin <= 1'b1;
          if (plen(bus.op) > 2) m_cnt <= m_cnt + 1;
        end else m_k <= m_k + 1;
      end
    end
  always @(negedge clk) begin
    chk("ctl", 64'(v), 64'(ev));
    chk("ctl4", 64'(v4), 64'(ev));
    chk("state", 64'(sd), 64'(es));
    chk("state4", 64'(sd4), 64'(es));
    chk("cnt", 64'(cnt), 64'(m_cnt));
    chk("cnt4", 64'(cnt4), 64'(m_cnt[3:0]));
    chk("wr_excl", 64'(bus.mem_write & bus.reg_write), 64'(0));
    if (bus.ir_write) n_irw <= n_irw + 1;
  end
  task automatic run(input logic [5:0] o, input int fw, input int mw, output int cyc);
    int f = fw, m = mw, s;
    cyc = 0;
    bus.op = o;
    do begin
      s = exp_state(o, m_k);
      if (s == 0 && f > 0) begin bus.mem_ready = 1'b0; f--; end
      else if ((s == 3 || s == 5) && m > 0) begin bus.mem_ready = 1'b0; m--; end
      else bus.mem_ready = 1'b1;
      @(posedge clk);
      #1 cyc++;
    end while (!m_fin && cyc < 50);
    chk("retire_bound", 64'(m_fin), 64'(1));
  endtask
  initial begin
    int c, c0, i0;
    bus.op = 6'b000000;
    bus.mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_cnt", 64'(cnt), 64'(0));
    chk("reset_state", 64'(sd), 64'(0));
    chk("reset_ctl", 64'(v), 64'(0));
    rst_n = 1'b1;
    run(6'b000000, 0, 0, c);
    chk("r_cycles", 64'(c), 64'(4));
    chk("r_cnt", 64'(cnt), 64'(1));
    i0 = n_irw;
    run(6'b100011, 2, 3, c);
    chk("lw_cycles", 64'(c), 64'(10));
    chk("lw_irw", 64'(n_irw - i0), 64'(1));
    chk("lw_cnt", 64'(cnt), 64'(2));
    run(6'b101011, 0, 0, c);
    chk("sw_cycles", 64'(c), 64'(4));
    chk("sw_cnt", 64'(cnt), 64'(3));
    run(6'b000100, 0, 0, c0);
    run(6'b000010, 0, 0, c);
    chk("bj_cycles", 64'(c0 + c), 64'(6));
    chk("bj_cnt", 64'(cnt), 64'(5));
    run(6'b001000, 0, 0, c);
    chk("ill_cycles", 64'(c), 64'(2));
    chk("ill_cnt", 64'(cnt), 64'(5));
    bus.op = 6'b100011;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.mem_ready = 1'b0;
    chk("memrd_state", 64'(sd), 64'(3));
    chk("memrd_read", 64'(bus.mem_read), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk("midrst_ctl", 64'(v), 64'(0));
    chk("midrst_state", 64'(sd), 64'(0));
    chk("midrst_cnt", 64'(cnt), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) run(6'b000000, 0, 0, c);
    chk("wrap_cnt4_15", 64'(cnt4), 64'(15));
    run(6'b000000, 0, 0, c);
    chk("wrap_cnt4_0", 64'(cnt4), 64'(0));
    chk("wrap_cnt32", 64'(cnt), 64'(16));
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath. It replaces single-cycle opcode decode with a sequenced Moore controller.
- Each cycle it drives the PC, IR, memory, register-file and ALU-source/ALUOp controls. The ALUOp it drives feeds the existing ALU control decode.
- Supports R-format, lw, sw, beq and j, and stalls on a memory ready handshake.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- JUMP_EN, 1, when 1 opcode 000010 (j) is legal; when 0 it is treated as illegal.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode from the instruction register, IR[31:26]; stable from DECODE onward.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero (beq).
- pc_source  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back data select: 1 = MDR.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  to ALU control: 00 = add, 01 = subtract, 10 = funct.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode.
- retired_cnt  out  CNT_W  count of retired instructions.
- state_dbg  out  4  current state encoding.

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9.
  - Encodings 10-15 are unreachable; if entered, the next state is FETCH.
- Reset (rst_n=0, asynchronous):
  - state=FETCH, retired_cnt=0.
  - All control outputs, instr_done and illegal_op are forced 0 while rst_n=0.
  - The first FETCH controls appear in the cycle after rst_n deasserts.
  - Reset mid-instruction abandons the instruction with no write.
- Outputs are decoded combinationally from the state (Moore); mem_ready gates the write enables in the memory states. Any signal not listed for a state is 0.
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready; pc_source=00. Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alu_src_b=11, alu_op=00 (branch target precompute). Next state by op:
    - 100011 or 101011 -> MEMADDR.
    - 000000 -> EXEC.
    - 000100 -> BRANCH.
    - 000010 -> JUMP (only if JUMP_EN=1).
    - Any other opcode -> FETCH, with illegal_op=1 this cycle.
  - MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for op 100011, else MEMWR.
  - MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
  - MEMWR: mem_write=1, iord=1. Hold until mem_ready=1; then instr_done=1 and next state FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state RWB.
  - RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Next state FETCH.
  - JUMP: pc_write=1, pc_source=10, instr_done=1. Next state FETCH.
- Latency with mem_ready tied 1:
  - lw = 5 cycles.
  - sw = 4 cycles.
  - R-format = 4 cycles.
  - beq = 3 cycles.
  - j = 3 cycles.
  - Each memory wait cycle adds 1.
- mem_write and reg_write are never asserted in the same cycle.
- retired_cnt increments by 1 on each clock edge where instr_done=1. It wraps from all-ones to 0 with no flag.
- Illegal opcodes do not increment retired_cnt.
- mem_ready is ignored in states other than FETCH, MEMRD and MEMWR.

Test Plan:
- Reset and R-format:
  - Stimulus: rst_n low for 3 cycles, then released with mem_ready=1 and op=000000.
  - Required: state_dbg sequence 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. retired_cnt=1 after RWB.
- lw with memory stall:
  - Stimulus: op=100011; mem_ready held 0 for 2 cycles in FETCH and 3 cycles in MEMRD.
  - Required: 10 cycles total. ir_write pulses exactly once. mem_to_reg=1 with reg_write=1 in MEMWB.
- sw:
  - Stimulus: op=101011, mem_ready=1.
  - Required: sequence 0,1,2,5. mem_write=1 and iord=1 in state 5. instr_done pulses in state 5. reg_write stays 0 throughout.
- beq then j:
  - Stimulus: op=000100, then op=000010, JUMP_EN=1.
  - Required: BRANCH asserts pc_write_cond=1, pc_source=01, alu_op=01. JUMP asserts pc_write=1, pc_source=10. retired_cnt advances by 2 over 6 cycles.
- Illegal opcode and mid-instruction reset:
  - Stimulus: op=001000.
    - Required: illegal_op pulses in DECODE, next state FETCH, retired_cnt unchanged.
  - Stimulus: rst_n asserted while in MEMRD.
    - Required: outputs go 0 immediately, state=0, retired_cnt=0.
- Counter wrap:
  - Stimulus: CNT_W=4, 16 R-format instructions.
  - Required: retired_cnt returns to 0.
